// File: rtl/instruction_sequencer_pkg.sv
// rtl/instruction_sequencer_pkg.sv - opcodes, instruction word layout and slot timing for instruction_sequencer
package instr_seq_pkg;

    localparam int INSTR_W       = 34;
    localparam int DEF_SHORT_LAT = 3;
    localparam int DEF_LONG_LAT  = 21;

    localparam logic [2:0] OP_WR  = 3'd0;
    localparam logic [2:0] OP_RD  = 3'd1;
    localparam logic [2:0] OP_NOT = 3'd2;
    localparam logic [2:0] OP_AND = 3'd3;
    localparam logic [2:0] OP_OR  = 3'd4;
    localparam logic [2:0] OP_ADD = 3'd5;
    localparam logic [2:0] OP_SUB = 3'd6;
    localparam logic [2:0] OP_SHL = 3'd7;
    localparam logic [2:0] OP_NOP = 3'b001;

    // Field order fixes the bit positions: op [33:31], ra1 [30:26], ra2 [25:21], wa [20:16], wdata [15:0]
    typedef struct packed {
        logic [2:0]  op;
        logic [4:0]  ra1;
        logic [4:0]  ra2;
        logic [4:0]  wa;
        logic [15:0] wdata;
    } instr_t;

    function automatic int slot_len(input logic [2:0] op,
                                    input int short_lat = DEF_SHORT_LAT,
                                    input int long_lat  = DEF_LONG_LAT);
        return (op > OP_OR) ? long_lat : short_lat;
    endfunction

endpackage

// File: rtl/instruction_sequencer_if.sv
// rtl/instruction_sequencer_if.sv - host instruction push handshake
interface instr_seq_if;
    import instr_seq_pkg::*;

    logic               instr_valid;
    logic               instr_ready;
    logic [INSTR_W-1:0] instr_word;

    modport master (output instr_valid, output instr_word, input instr_ready);
    modport slave  (input instr_valid, input instr_word, output instr_ready);

endinterface

// File: rtl/instruction_sequencer_fifo.sv
// rtl/instruction_sequencer_fifo.sv - synchronous instruction FIFO with full/empty/count
module seq_instr_fifo #(
    parameter int WIDTH = 34,
    parameter int DEPTH = 8,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign full  = (count_q == (AW+1)'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign rdata = mem_q[rd_ptr_q];

    // A full FIFO still takes a write when the head leaves in the same cycle
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q + AW'(do_push);
        rd_ptr_d = rd_ptr_q + AW'(do_pop);
        count_d  = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/instruction_sequencer.sv
// rtl/instruction_sequencer.sv - issue stage feeding instruction_processor one slot per instruction
// INSTR_SEQ_PERF_EN adds retired_cnt/nop_cnt outputs.
module instruction_sequencer
    import instr_seq_pkg::*;
#(
    parameter int DEPTH     = 8,
    parameter int SHORT_LAT = DEF_SHORT_LAT,
    parameter int LONG_LAT  = DEF_LONG_LAT
) (
    input  logic        clk,
    input  logic        rst_n,
    instr_seq_if.slave  host,
    input  logic        done,
    input  logic [15:0] calculated_value,
    output logic [2:0]  opcode,
    output logic [4:0]  read_address1,
    output logic [4:0]  read_address2,
    output logic [4:0]  write_address,
    output logic [15:0] write_data,
    output logic        busy,
    output logic        result_valid,
    output logic [15:0] result,
    output logic        sync_err
`ifdef INSTR_SEQ_PERF_EN
    ,
    output logic [15:0] retired_cnt,
    output logic [15:0] nop_cnt
`endif
);

    localparam int     CNT_W    = $clog2(LONG_LAT + 1);
    localparam instr_t NOP_SLOT = instr_t'({OP_NOP, 31'd0});

    typedef enum logic {S_LOAD, S_RUN} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    instr_t             slot_q, slot_d;
    logic               busy_q, busy_d, first_q, first_d;
    logic               chk_q, chk_d, cap_q, cap_d;
    logic               result_valid_q, result_valid_d, sync_err_q, sync_err_d;
    logic [15:0]        result_q, result_d;

    instr_t             head;
    logic [$clog2(DEPTH):0] fifo_count;
    logic               fifo_full, fifo_empty, have_word, pop;

    seq_instr_fifo #(.WIDTH(INSTR_W), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (host.instr_valid && host.instr_ready),
        .wdata (host.instr_word),
        .pop   (pop),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign host.instr_ready = !fifo_full;
    assign have_word        = !fifo_empty && (fifo_count != '0);

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        slot_d         = slot_q;
        busy_d         = busy_q;
        first_d        = first_q;
        chk_d          = 1'b0;
        cap_d          = 1'b0;
        result_valid_d = 1'b0;
        result_d       = result_q;
        sync_err_d     = sync_err_q || (chk_q && !done);
        pop            = 1'b0;
        if (cap_q) begin
            result_d       = calculated_value;
            result_valid_d = 1'b1;
        end
        // LOAD shares its edge with the last RUN edge, so slots abut with no bubble
        if (state_q == S_LOAD) begin
            chk_d   = !first_q;
            cap_d   = (slot_q.op > OP_OR);
            first_d = 1'b0;
            pop     = have_word;
            slot_d  = have_word ? head : NOP_SLOT;
            busy_d  = have_word;
            cnt_d   = CNT_W'(slot_len(slot_d.op, SHORT_LAT, LONG_LAT));
            state_d = S_RUN;
        end else begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(2)) state_d = S_LOAD;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_LOAD;
            cnt_q          <= '0;
            slot_q         <= NOP_SLOT;
            busy_q         <= 1'b0;
            first_q        <= 1'b1;
            chk_q          <= 1'b0;
            cap_q          <= 1'b0;
            result_valid_q <= 1'b0;
            result_q       <= '0;
            sync_err_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            slot_q         <= slot_d;
            busy_q         <= busy_d;
            first_q        <= first_d;
            chk_q          <= chk_d;
            cap_q          <= cap_d;
            result_valid_q <= result_valid_d;
            result_q       <= result_d;
            sync_err_q     <= sync_err_d;
        end
    end

    assign opcode        = slot_q.op;
    assign read_address1 = slot_q.ra1;
    assign read_address2 = slot_q.ra2;
    assign write_address = slot_q.wa;
    assign write_data    = slot_q.wdata;
    assign busy          = busy_q;
    assign result_valid  = result_valid_q;
    assign result        = result_q;
    assign sync_err      = sync_err_q;

`ifdef INSTR_SEQ_PERF_EN
    logic [15:0] retired_q, retired_d, nops_q, nops_d;

    always_comb begin
        retired_d = retired_q;
        nops_d    = nops_q;
        if (state_q == S_LOAD && !first_q) begin
            if (busy_q) retired_d = retired_q + 16'd1;
            else        nops_d    = nops_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retired_q <= '0;
            nops_q    <= '0;
        end else begin
            retired_q <= retired_d;
            nops_q    <= nops_d;
        end
    end

    assign retired_cnt = retired_q;
    assign nop_cnt     = nops_q;
`endif

endmodule

// File: tb/tb_instruction_sequencer.sv
// tb/tb_instruction_sequencer.sv - scoreboard bench for instruction_sequencer with a processor model
`timescale 1ns/1ps
module tb_instruction_sequencer;
    import instr_seq_pkg::*;

    localparam int DEPTH = 8;
    localparam int SL    = 3;
    localparam int LL    = 21;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    instr_seq_if host_if();
    logic        done;
    logic [15:0] calculated_value = '0;
    logic [2:0]  opcode;
    logic [4:0]  read_address1, read_address2, write_address;
    logic [15:0] write_data, result;
    logic        busy, result_valid, sync_err;
`ifdef INSTR_SEQ_PERF_EN
    logic [15:0] retired_cnt, nop_cnt;
`endif

    instruction_sequencer #(.DEPTH(DEPTH), .SHORT_LAT(SL), .LONG_LAT(LL)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .host             (host_if),
        .done             (done),
        .calculated_value (calculated_value),
        .opcode           (opcode),
        .read_address1    (read_address1),
        .read_address2    (read_address2),
        .write_address    (write_address),
        .write_data       (write_data),
        .busy             (busy),
        .result_valid     (result_valid),
        .result           (result),
        .sync_err         (sync_err)
`ifdef INSTR_SEQ_PERF_EN
        ,
        .retired_cnt      (retired_cnt),
        .nop_cnt          (nop_cnt)
`endif
    );

    int n_pass = 0;
    int n_total = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Processor model: samples the sequencer outputs when its cycle counter is 0
    logic [15:0] regs [32];
    int   pcyc = 1;
    int   cyc = 0;
    int   samp_cyc = -10;
    logic drop_done = 1'b0;
    logic [15:0] a, b;

    initial for (int i = 0; i < 32; i++) regs[i] = '0;

    assign done = (pcyc == 0) && !drop_done;
    assign a = regs[read_address1];
    assign b = regs[read_address2];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst_n) pcyc <= 1;
        else if (pcyc == 0) begin
            samp_cyc <= cyc;
            pcyc <= ((opcode > 3'd4) ? LL : SL) - 1;
            case (opcode)
                3'd0: begin regs[write_address] <= write_data; calculated_value <= write_data; end
                3'd1: calculated_value <= a;
                3'd2: begin regs[write_address] <= ~a;      calculated_value <= ~a;      end
                3'd3: begin regs[write_address] <= a & b;   calculated_value <= a & b;   end
                3'd4: begin regs[write_address] <= a | b;   calculated_value <= a | b;   end
                3'd5: begin regs[write_address] <= a + b;   calculated_value <= a + b;   end
                3'd6: begin regs[write_address] <= a - b;   calculated_value <= a - b;   end
                default: begin regs[write_address] <= a << b[3:0]; calculated_value <= a << b[3:0]; end
            endcase
        end else pcyc <= pcyc - 1;
    end

    typedef struct { logic [33:0] word; bit no_gap; } exp_t;
    exp_t        exp_q[$];
    logic [15:0] res_q[$];
    int nop_samples = 0;
    int nops_since_busy = 0;

    // Monitor: checks each slot as the processor sees it, and every captured result
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (pcyc == 0) begin
                if (busy) begin
                    if (exp_q.size() == 0) check("unexpected_busy", busy, 1'b0);
                    else begin
                        e = exp_q.pop_front();
                        check("slot_word", {opcode, read_address1, read_address2, write_address, write_data}, e.word);
                        if (e.no_gap) check("slot_gap_nops", nops_since_busy, 0);
                    end
                    nops_since_busy = 0;
                end else begin
                    check("nop_slot", {opcode, read_address1, read_address2, write_address, write_data},
                          {OP_NOP, 31'd0});
                    nops_since_busy++;
                    nop_samples++;
                end
            end
            if (result_valid) begin
                if (res_q.size() == 0) check("unexpected_result_valid", result_valid, 1'b0);
                else begin
                    check("result", result, res_q.pop_front());
                    check("result_timing", samp_cyc, cyc - 1);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #2; end
    endtask

    function automatic logic [33:0] mk(input logic [2:0] op, input logic [4:0] r1, input logic [4:0] r2,
                                       input logic [4:0] wa, input logic [15:0] wd);
        return {op, r1, r2, wa, wd};
    endfunction

    task automatic push_word(input logic [33:0] w, input bit no_gap, output bit blocked);
        int t = 0;
        host_if.instr_valid = 1'b1;
        host_if.instr_word  = w;
        blocked = !host_if.instr_ready;
        while (!host_if.instr_ready && t < 200) begin tick(1); t++; end
        if (!host_if.instr_ready) begin
            check("push_timeout", host_if.instr_ready, 1'b1);
            host_if.instr_valid = 1'b0;
            return;
        end
        tick(1);
        host_if.instr_valid = 1'b0;
        exp_q.push_back('{word: w, no_gap: no_gap});
    endtask

    task automatic drain(input string nm, input int lim);
        int t = 0;
        while ((exp_q.size() != 0 || res_q.size() != 0) && t < lim) begin tick(1); t++; end
        tick(2);
        check(nm, exp_q.size() + res_q.size(), 0);
    endtask

    task automatic wait_issued(input int lim);
        int t = 0;
        while (exp_q.size() != 0 && t < lim) begin tick(1); t++; end
        check("issue_wait", exp_q.size(), 0);
    endtask

    initial begin
        bit blk;
        int first_blk;
        int nops0;
        int t;
        host_if.instr_valid = 1'b0;
        host_if.instr_word  = '0;
        rst_n = 1'b0;
        tick(LL + 2);
        check("rst_opcode", opcode, OP_NOP);
        check("rst_fields", {read_address1, read_address2, write_address, write_data}, 0);
        check("rst_busy", busy, 1'b0);
        check("rst_result", {result_valid, result, sync_err}, 0);
        check("rst_ready", host_if.instr_ready, 1'b1);
        rst_n = 1'b1;

        nops0 = nop_samples;
        tick(12);
        check("idle_nop_slots", nop_samples - nops0, 4);
        check("idle_sync_err", sync_err, 1'b0);

        push_word(mk(OP_WR, 5'd0, 5'd0, 5'd5, 16'hABCD), 1'b0, blk);
        push_word(mk(OP_RD, 5'd5, 5'd0, 5'd0, 16'h0000), 1'b1, blk);
        drain("wr_rd_drain", 50);
        check("wr_rd_sync_err", sync_err, 1'b0);

        push_word(mk(OP_WR, 5'd0, 5'd0, 5'd5, 16'h0003), 1'b0, blk);
        push_word(mk(OP_WR, 5'd0, 5'd0, 5'd6, 16'h0004), 1'b0, blk);
        push_word(mk(OP_ADD, 5'd5, 5'd6, 5'd7, 16'h0000), 1'b0, blk); res_q.push_back(16'h0007);
        push_word(mk(OP_SUB, 5'd5, 5'd6, 5'd8, 16'h0000), 1'b0, blk); res_q.push_back(16'hFFFF);
        push_word(mk(OP_SHL, 5'd6, 5'd5, 5'd9, 16'h0000), 1'b0, blk); res_q.push_back(16'h0020);
        drain("alu_drain", 300);
        check("alu_sync_err", sync_err, 1'b0);

        push_word(mk(OP_ADD, 5'd6, 5'd6, 5'd10, 16'h0000), 1'b0, blk); res_q.push_back(16'h0008);
        wait_issued(20);
        first_blk = -1;
        for (int i = 0; i < DEPTH + 2; i++) begin
            push_word(mk(OP_WR, 5'd0, 5'd0, 5'(11 + i), 16'h1000 + 16'(i)), 1'b0, blk);
            if (blk && first_blk < 0) first_blk = i;
        end
        check("ready_low_after_depth", first_blk, DEPTH);
        drain("fill_drain", 300);
        check("fill_sync_err", sync_err, 1'b0);

        t = 0;
        while (pcyc != 0 && t < 30) begin tick(1); t++; end
        drop_done = 1'b1;
        tick(1);
        drop_done = 1'b0;
        check("sync_err_set", sync_err, 1'b1);
        tick(30);
        check("sync_err_sticky", sync_err, 1'b1);
        rst_n = 1'b0;
        tick(LL + 2);
        check("sync_err_cleared", sync_err, 1'b0);
        rst_n = 1'b1;
        tick(9);
        check("sync_err_realigned", sync_err, 1'b0);

        push_word(mk(OP_ADD, 5'd5, 5'd6, 5'd7, 16'h0000), 1'b0, blk);
        wait_issued(20);
        for (int i = 0; i < 3; i++) push_word(mk(OP_WR, 5'd0, 5'd0, 5'(20 + i), 16'h2000 + 16'(i)), 1'b0, blk);
        tick(3);
        rst_n = 1'b0;
        #1;
        check("midrst_opcode", opcode, OP_NOP);
        check("midrst_fields", {read_address1, read_address2, write_address, write_data}, 0);
        check("midrst_busy", busy, 1'b0);
        check("midrst_ready", host_if.instr_ready, 1'b1);
        exp_q.delete();
        res_q.delete();
        tick(LL + 2);
        rst_n = 1'b1;
        nops0 = nop_samples;
        tick(12);
        check("postrst_nop_slots", nop_samples - nops0, 4);
        check("postrst_ready", host_if.instr_ready, 1'b1);
        check("postrst_sync_err", sync_err, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        check("watchdog", 1'b1, 1'b0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
